fp_special_prep: RTL and testbench

- Parametrised, pipelined successor to the adder's combinational special-case/denorm check.
- Classifies both IEEE-754 operands and resolves the special-case result (NaN/Inf/Zero) for ADD, SUB and MUL.
- Emits hidden-bit-extended significands and denorm-adjusted exponents.
- Sits between the FPU operand fetch and the align/multiply datapath; 2-stage pipeline with valid/ready on both sides.

---
 rtl/fp_special_prep_pkg.sv | 47 ++++
 rtl/fp_special_prep_classify.sv | 37 +++
 rtl/fp_special_prep.sv | 177 +++++++++++++++++
 tb/tb_fp_special_prep.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_special_prep_pkg.sv
// Shared types for the FPU special-case prep stage.
// Operand classes, special-result codes, op codes and the classifier.
package fp_special_prep_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'd0,
      OP_SUB  = 2'd1,
      OP_MUL  = 2'd2,
      OP_RSVD = 2'd3
   } fp_op_t;

   typedef enum logic [1:0] {
      ERR_NOERR = 2'd0,
      ERR_ZERO  = 2'd1,
      ERR_NAN   = 2'd2,
      ERR_INF   = 2'd3
   } i_err_t;

   typedef enum logic [2:0] {
      CLS_ZERO = 3'd0,
      CLS_SUB  = 3'd1,
      CLS_NORM = 3'd2,
      CLS_INF  = 3'd3,
      CLS_QNAN = 3'd4,
      CLS_SNAN = 3'd5
   } fp_cls_t;

   // Width-independent: callers reduce their fields to these four flags.
   function automatic fp_cls_t classify(
      input logic exp_ones,
      input logic exp_zero,
      input logic man_zero,
      input logic man_msb
   );
      fp_cls_t c;
      c = CLS_NORM;
      if (exp_ones) begin
         if (man_zero)     c = CLS_INF;
         else if (man_msb) c = CLS_QNAN;
         else              c = CLS_SNAN;
      end else if (exp_zero) begin
         c = man_zero ? CLS_ZERO : CLS_SUB;
      end
      return c;
   endfunction

endpackage

// File: rtl/fp_special_prep_classify.sv
// Per-operand classification and denorm adjustment.
// FP_PREP_DAZ_EN flushes subnormal operands to zero.
module fp_operand_classify
   import fp_special_prep_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W-1:0] exp_f,
   input  logic [MAN_W-1:0] man_f,
   output logic [2:0]       cls,
   output logic [EXP_W-1:0] exp_d,
   output logic [MAN_W:0]   man_ext
);

   fp_cls_t c;

   always_comb begin
      c = classify(&exp_f, ~|exp_f, ~|man_f, man_f[MAN_W-1]);
`ifdef FP_PREP_DAZ_EN
      if (c == CLS_SUB) c = CLS_ZERO;
`else
      c = c;
`endif
      cls     = c;
      exp_d   = exp_f;
      man_ext = {1'b1, man_f};
      if (c == CLS_SUB) begin
         exp_d   = EXP_W'(1);
         man_ext = {1'b0, man_f};
      end else if (c == CLS_ZERO) begin
         exp_d   = '0;
         man_ext = '0;
      end
   end

endmodule

// File: rtl/fp_special_prep.sv
// Two-stage special-case resolver for ADD/SUB/MUL with valid/ready.
// Build option FP_PREP_DAZ_EN: treat subnormal operands as zero.
module fp_special_prep
   import fp_special_prep_pkg::*;
#(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_err,
   output logic             out_sign,
   output logic             out_invalid,
   output logic [2:0]       out_cls_a,
   output logic [2:0]       out_cls_b,
   output logic [EXP_W-1:0] out_exp_a,
   output logic [EXP_W-1:0] out_exp_b,
   output logic [MAN_W:0]   out_man_a,
   output logic [MAN_W:0]   out_man_b,
   output logic [1:0]       out_op
);

   logic             ld1, ld2;
   logic [2:0]       cls_a, cls_b;
   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W:0]   man_a, man_b;

   logic             v1_q, v1_d, sa1_q, sa1_d, sb1_q, sb1_d;
   logic [1:0]       op1_q, op1_d;
   logic [2:0]       ca1_q, ca1_d, cb1_q, cb1_d;
   logic [EXP_W-1:0] ea1_q, ea1_d, eb1_q, eb1_d;
   logic [MAN_W:0]   ma1_q, ma1_d, mb1_q, mb1_d;

   logic             v2_q, v2_d, sg2_q, sg2_d, inv2_q, inv2_d;
   logic [1:0]       err2_q, err2_d, op2_q, op2_d;
   logic [2:0]       ca2_q, ca2_d, cb2_q, cb2_d;
   logic [EXP_W-1:0] ea2_q, ea2_d, eb2_q, eb2_d;
   logic [MAN_W:0]   ma2_q, ma2_d, mb2_q, mb2_d;

   i_err_t res_err;
   logic   res_sign, res_inv;
   logic   sb_e, eff_sub, is_mul, nan_a, nan_b, snan;
   logic   inf_a, inf_b, zero_a, zero_b, same;

   fp_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
      .exp_f   (in_a[W-2:MAN_W]),
      .man_f   (in_a[MAN_W-1:0]),
      .cls     (cls_a),
      .exp_d   (exp_a),
      .man_ext (man_a)
   );

   fp_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
      .exp_f   (in_b[W-2:MAN_W]),
      .man_f   (in_b[MAN_W-1:0]),
      .cls     (cls_b),
      .exp_d   (exp_b),
      .man_ext (man_b)
   );

   assign ld2      = !v2_q || out_ready;
   assign ld1      = !v1_q || ld2;
   assign in_ready = rst || ld1;

   always_comb begin
      v1_d = v1_q; op1_d = op1_q; sa1_d = sa1_q; sb1_d = sb1_q;
      ca1_d = ca1_q; cb1_d = cb1_q; ea1_d = ea1_q; eb1_d = eb1_q;
      ma1_d = ma1_q; mb1_d = mb1_q;
      if (ld1) v1_d = in_valid;
      if (ld1 && in_valid) begin
         op1_d = in_op;  sa1_d = in_a[W-1]; sb1_d = in_b[W-1];
         ca1_d = cls_a;  cb1_d = cls_b;
         ea1_d = exp_a;  eb1_d = exp_b;
         ma1_d = man_a;  mb1_d = man_b;
      end
   end

   // Reserved op code falls through the ADD path.
   always_comb begin
      is_mul  = op1_q == OP_MUL;
      sb_e    = sb1_q ^ (op1_q == OP_SUB);
      eff_sub = sa1_q ^ sb_e;
      nan_a   = ca1_q == CLS_QNAN || ca1_q == CLS_SNAN;
      nan_b   = cb1_q == CLS_QNAN || cb1_q == CLS_SNAN;
      snan    = ca1_q == CLS_SNAN || cb1_q == CLS_SNAN;
      inf_a   = ca1_q == CLS_INF;
      inf_b   = cb1_q == CLS_INF;
      zero_a  = ca1_q == CLS_ZERO;
      zero_b  = cb1_q == CLS_ZERO;
      same    = ea1_q == eb1_q && ma1_q == mb1_q;
      res_err  = ERR_NOERR;
      res_sign = 1'b0;
      res_inv  = 1'b0;
      if (nan_a || nan_b) begin
         res_err = ERR_NAN;
         res_inv = snan;
      end else if (is_mul) begin
         if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            res_err = ERR_NAN;
            res_inv = 1'b1;
         end else if (inf_a || inf_b) begin
            res_err  = ERR_INF;
            res_sign = sa1_q ^ sb1_q;
         end else if (zero_a || zero_b) begin
            res_err  = ERR_ZERO;
            res_sign = sa1_q ^ sb1_q;
         end
      end else begin
         if (inf_a && inf_b && eff_sub) begin
            res_err = ERR_NAN;
            res_inv = 1'b1;
         end else if (inf_a) begin
            res_err  = ERR_INF;
            res_sign = sa1_q;
         end else if (inf_b) begin
            res_err  = ERR_INF;
            res_sign = sb_e;
         end else if (zero_a && zero_b) begin
            res_err  = ERR_ZERO;
            res_sign = sa1_q & sb_e;
         end else if (eff_sub && same) begin
            res_err = ERR_ZERO;
         end
      end
   end

   always_comb begin
      v2_d = v2_q; err2_d = err2_q; sg2_d = sg2_q; inv2_d = inv2_q;
      ca2_d = ca2_q; cb2_d = cb2_q; ea2_d = ea2_q; eb2_d = eb2_q;
      ma2_d = ma2_q; mb2_d = mb2_q; op2_d = op2_q;
      if (ld2) v2_d = v1_q;
      if (ld2 && v1_q) begin
         err2_d = res_err; sg2_d = res_sign; inv2_d = res_inv;
         ca2_d = ca1_q; cb2_d = cb1_q; ea2_d = ea1_q; eb2_d = eb1_q;
         ma2_d = ma1_q; mb2_d = mb1_q; op2_d = op1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0; op1_q <= '0; sa1_q <= 1'b0; sb1_q <= 1'b0;
         ca1_q <= '0; cb1_q <= '0; ea1_q <= '0; eb1_q <= '0;
         ma1_q <= '0; mb1_q <= '0;
         v2_q <= 1'b0; err2_q <= '0; sg2_q <= 1'b0; inv2_q <= 1'b0;
         ca2_q <= '0; cb2_q <= '0; ea2_q <= '0; eb2_q <= '0;
         ma2_q <= '0; mb2_q <= '0; op2_q <= '0;
      end else begin
         v1_q <= v1_d; op1_q <= op1_d; sa1_q <= sa1_d; sb1_q <= sb1_d;
         ca1_q <= ca1_d; cb1_q <= cb1_d; ea1_q <= ea1_d; eb1_q <= eb1_d;
         ma1_q <= ma1_d; mb1_q <= mb1_d;
         v2_q <= v2_d; err2_q <= err2_d; sg2_q <= sg2_d; inv2_q <= inv2_d;
         ca2_q <= ca2_d; cb2_q <= cb2_d; ea2_q <= ea2_d; eb2_q <= eb2_d;
         ma2_q <= ma2_d; mb2_q <= mb2_d; op2_q <= op2_d;
      end
   end

   assign out_valid   = v2_q;
   assign out_err     = err2_q;
   assign out_sign    = sg2_q;
   assign out_invalid = inv2_q;
   assign out_cls_a   = ca2_q;
   assign out_cls_b   = cb2_q;
   assign out_exp_a   = ea2_q;
   assign out_exp_b   = eb2_q;
   assign out_man_a   = ma2_q;
   assign out_man_b   = mb2_q;
   assign out_op      = op2_q;

endmodule

// File: tb/tb_fp_special_prep.sv
// Scoreboard bench for fp_special_prep: directed vectors, stall, reset.
module tb_fp_special_prep;
   import fp_special_prep_pkg::*;

   typedef struct packed {
      logic [1:0]  err;
      logic        sign;
      logic        inv;
      logic [2:0]  ca;
      logic [2:0]  cb;
      logic [7:0]  ea;
      logic [7:0]  eb;
      logic [23:0] ma;
      logic [23:0] mb;
      logic [1:0]  op;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = 2'd0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [1:0]  out_err;
   logic        out_sign, out_invalid;
   logic [2:0]  out_cls_a, out_cls_b;
   logic [7:0]  out_exp_a, out_exp_b;
   logic [23:0] out_man_a, out_man_b;
   logic [1:0]  out_op;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   exp_t sb_q[$];
   int   tacc_q[$];
   bit   lat_q[$];
   exp_t act;

   fp_special_prep dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_err(out_err), .out_sign(out_sign),
      .out_invalid(out_invalid),
      .out_cls_a(out_cls_a), .out_cls_b(out_cls_b),
      .out_exp_a(out_exp_a), .out_exp_b(out_exp_b),
      .out_man_a(out_man_a), .out_man_b(out_man_b),
      .out_op(out_op)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign act = {out_err, out_sign, out_invalid, out_cls_a, out_cls_b,
                 out_exp_a, out_exp_b, out_man_a, out_man_b, out_op};

   function automatic exp_t mk(
      input logic [1:0] err, input logic sign, input logic inv,
      input logic [2:0] ca, input logic [2:0] cb,
      input logic [7:0] ea, input logic [7:0] eb,
      input logic [23:0] ma, input logic [23:0] mb,
      input logic [1:0] op);
      return {err, sign, inv, ca, cb, ea, eb, ma, mb, op};
   endfunction

   // Monitor: pops one expectation per accepted output beat.
   always @(negedge clk) begin
      exp_t e;
      int   t;
      bit   l;
      if (!rst && out_valid && out_ready) begin
         n_chk++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output got=%h", act);
         end else begin
            e = sb_q.pop_front();
            t = tacc_q.pop_front();
            l = lat_q.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL result got=%h want=%h", act, e);
            end
            if (l) begin
               n_chk++;
               if (cyc != t + 2) begin
                  n_fail++;
                  $display("FAIL latency got=%0d want=2", cyc - t);
               end
            end
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e,
                       input bit chk_lat);
      int n;
      n = 0;
      in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_chk++; n_fail++;
         $display("FAIL send_timeout in_ready=0 want=1");
      end else begin
         sb_q.push_back(e);
         tacc_q.push_back(cyc);
         lat_q.push_back(chk_lat);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      n_chk++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_%s left=%0d want=0", name, sb_q.size());
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   exp_t st[6];
   logic [31:0] sa[6], sbv[6];
   logic [1:0]  so[6];
   exp_t ed;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready_after", 32'(in_ready), 32'd1);
      chk("rst_out_err", 32'(out_err), 32'd0);
      @(posedge clk); #1;

      send(OP_SUB, 32'h7F800000, 32'h7F800000,
           mk(ERR_NAN, 0, 1, CLS_INF, CLS_INF, 8'hFF, 8'hFF,
              24'h800000, 24'h800000, OP_SUB), 1);
      drain("inf_sub");
      send(OP_ADD, 32'h3F800000, 32'hBF800000,
           mk(ERR_ZERO, 0, 0, CLS_NORM, CLS_NORM, 8'h7F, 8'h7F,
              24'h800000, 24'h800000, OP_ADD), 0);
      send(OP_ADD, 32'h80000000, 32'h80000000,
           mk(ERR_ZERO, 1, 0, CLS_ZERO, CLS_ZERO, 8'h00, 8'h00,
              24'h0, 24'h0, OP_ADD), 0);
`ifdef FP_PREP_DAZ_EN
      ed = mk(ERR_NOERR, 0, 0, CLS_ZERO, CLS_NORM, 8'h00, 8'h7F,
              24'h000000, 24'h800000, OP_ADD);
`else
      ed = mk(ERR_NOERR, 0, 0, CLS_SUB, CLS_NORM, 8'h01, 8'h7F,
              24'h000001, 24'h800000, OP_ADD);
`endif
      send(OP_ADD, 32'h00000001, 32'h3F800000, ed, 0);
      send(OP_MUL, 32'hFF800000, 32'h00000000,
           mk(ERR_NAN, 0, 1, CLS_INF, CLS_ZERO, 8'hFF, 8'h00,
              24'h800000, 24'h0, OP_MUL), 0);
      send(OP_MUL, 32'h7FA00000, 32'h3F800000,
           mk(ERR_NAN, 0, 1, CLS_SNAN, CLS_NORM, 8'hFF, 8'h7F,
              24'hA00000, 24'h800000, OP_MUL), 0);
      send(OP_RSVD, 32'h3F800000, 32'hBF800000,
           mk(ERR_ZERO, 0, 0, CLS_NORM, CLS_NORM, 8'h7F, 8'h7F,
              24'h800000, 24'h800000, OP_RSVD), 0);
      send(OP_ADD, 32'h7FC00000, 32'h3F800000,
           mk(ERR_NAN, 0, 0, CLS_QNAN, CLS_NORM, 8'hFF, 8'h7F,
              24'hC00000, 24'h800000, OP_ADD), 0);
      drain("directed");

      so[0] = OP_ADD; sa[0] = 32'h40000000; sbv[0] = 32'h3F800000;
      st[0] = mk(ERR_NOERR, 0, 0, CLS_NORM, CLS_NORM, 8'h80, 8'h7F,
                 24'h800000, 24'h800000, OP_ADD);
      so[1] = OP_ADD; sa[1] = 32'h40400000; sbv[1] = 32'h3F800000;
      st[1] = mk(ERR_NOERR, 0, 0, CLS_NORM, CLS_NORM, 8'h80, 8'h7F,
                 24'hC00000, 24'h800000, OP_ADD);
      so[2] = OP_MUL; sa[2] = 32'h00000000; sbv[2] = 32'h40000000;
      st[2] = mk(ERR_ZERO, 0, 0, CLS_ZERO, CLS_NORM, 8'h00, 8'h80,
                 24'h0, 24'h800000, OP_MUL);
      so[3] = OP_MUL; sa[3] = 32'h80000000; sbv[3] = 32'h40000000;
      st[3] = mk(ERR_ZERO, 1, 0, CLS_ZERO, CLS_NORM, 8'h00, 8'h80,
                 24'h0, 24'h800000, OP_MUL);
      so[4] = OP_SUB; sa[4] = 32'h7F800000; sbv[4] = 32'h3F800000;
      st[4] = mk(ERR_INF, 0, 0, CLS_INF, CLS_NORM, 8'hFF, 8'h7F,
                 24'h800000, 24'h800000, OP_SUB);
      so[5] = OP_ADD; sa[5] = 32'h3F800000; sbv[5] = 32'hFF800000;
      st[5] = mk(ERR_INF, 1, 0, CLS_NORM, CLS_INF, 8'h7F, 8'hFF,
                 24'h800000, 24'h800000, OP_ADD);

      fork
         begin
            for (int i = 0; i < 6; i++) send(so[i], sa[i], sbv[i], st[i], 0);
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain("stream");

      out_ready = 1'b0;
      send(so[0], sa[0], sbv[0], st[0], 0);
      send(so[1], sa[1], sbv[1], st[1], 0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      sb_q.delete(); tacc_q.delete(); lat_q.delete();
      out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      send(so[5], sa[5], sbv[5], st[5], 1);
      drain("recover");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
